// File: rtl/clink_ctrl_pkg.sv
// rtl/clink_ctrl_pkg.sv - shared types and constants for the C-link cycle controller
package clink_ctrl_pkg;

   localparam int CNT_W = 16;

   localparam logic [1:0] CRC_PASS = 2'b01;
   localparam logic [1:0] CRC_FAIL = 2'b10;

   typedef enum logic [2:0] {
      IDLE,
      START,
      WAIT_TX,
      WAIT_RX,
      CHECK,
      HOLD
   } cyc_state_e;

   // States in which a cycle is still in flight and a wrap counts as an overrun.
   function automatic logic is_busy(input cyc_state_e s);
      return (s == WAIT_TX) || (s == WAIT_RX) || (s == CHECK);
   endfunction

endpackage

// File: rtl/clink_cycle_ctrl_if.sv
// rtl/clink_cycle_ctrl_if.sv - handshake and status bundle between link top level and cycle controller
interface clink_cycle_ctrl_if;
   import clink_ctrl_pkg::*;

   logic             ini_done;
   logic             da_valid;
   logic             tx_start;
   logic             rx_done;
   logic [1:0]       rx_crc_rslt;
   logic             ch1_sn_err;
   logic             ch1_crc_err;
   logic             ch1_DA_err;

   logic             tx_req;
   logic             cycle_sync;
   logic             link_ok;
   logic             link_fault;
   logic [CNT_W-1:0] bad_cnt;
   logic [CNT_W-1:0] to_cnt;

   modport master (
      output ini_done, da_valid, tx_start, rx_done, rx_crc_rslt,
             ch1_sn_err, ch1_crc_err, ch1_DA_err,
      input  tx_req, cycle_sync, link_ok, link_fault, bad_cnt, to_cnt
   );

   modport slave (
      input  ini_done, da_valid, tx_start, rx_done, rx_crc_rslt,
             ch1_sn_err, ch1_crc_err, ch1_DA_err,
      output tx_req, cycle_sync, link_ok, link_fault, bad_cnt, to_cnt
   );

endinterface

// File: rtl/clink_sat_cnt.sv
// rtl/clink_sat_cnt.sv - saturating up-counter with synchronous clear
module clink_sat_cnt #(
   parameter int           W   = 16,
   parameter logic [W-1:0] MAX = '1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] q
);

   // Clear has priority so a run counter can restart in the same clock it is hit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q <= '0;
      end else if (clr) begin
         q <= '0;
      end else if (inc && (q != MAX)) begin
         q <= q + W'(1);
      end
   end

endmodule

// File: rtl/clink_cycle_ctrl.sv
// rtl/clink_cycle_ctrl.sv - cyclic channel-1 exchange scheduler with cycle verdicts and link statistics
module clink_cycle_ctrl
   import clink_ctrl_pkg::*;
#(
   parameter int CYCLE_CNT    = 50000,
   parameter int TX_TIMEOUT   = 2000,
   parameter int RX_TIMEOUT   = 20000,
   parameter int FAULT_THRESH = 3
) (
   input  logic              sys_clk,
   input  logic              reset,
   clink_cycle_ctrl_if.slave bus
);

   localparam int CYC_W   = $clog2(CYCLE_CNT);
   localparam int TMR_MAX = (TX_TIMEOUT > RX_TIMEOUT) ? TX_TIMEOUT : RX_TIMEOUT;
   localparam int TMR_W   = $clog2(TMR_MAX + 1);
   localparam int RUN_W   = $clog2(FAULT_THRESH + 1);

   localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(CYCLE_CNT - 1);
   localparam logic [TMR_W-1:0] TX_LIM   = TMR_W'(TX_TIMEOUT);
   localparam logic [TMR_W-1:0] RX_LIM   = TMR_W'(RX_TIMEOUT);
   localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(FAULT_THRESH);
   localparam logic [RUN_W-1:0] RUN_SET  = RUN_W'(FAULT_THRESH - 1);

   cyc_state_e       state;
   cyc_state_e       cur_st;
   cyc_state_e       next_state;

   logic [CYC_W-1:0] cyc_cnt;
   logic             cyc_start;
   logic [TMR_W-1:0] tmr;
   logic [1:0]       crc_q;
   logic             chk_last;
   logic             sticky_err;
   logic             flag_any;
   logic             cycle_good;

   logic             tx_req_c;
   logic             overrun;
   logic             verdict_good;
   logic             verdict_bad;
   logic             to_event;

   logic             link_ok_q;
   logic             link_fault_q;
   logic [RUN_W-1:0] good_run;
   logic [RUN_W-1:0] bad_run;
   logic [CNT_W-1:0] bad_q;
   logic [CNT_W-1:0] to_q;

   always_ff @(posedge sys_clk or posedge reset) begin
      if (reset) begin
         cyc_cnt <= '0;
      end else if (!bus.ini_done || (cyc_cnt == CYC_LAST)) begin
         cyc_cnt <= '0;
      end else begin
         cyc_cnt <= cyc_cnt + CYC_W'(1);
      end
   end

   // Gating with reset keeps cycle_sync and tx_req quiet while reset is held.
   assign cyc_start = bus.ini_done && !reset && (cyc_cnt == '0);

   assign flag_any   = bus.ch1_sn_err || bus.ch1_crc_err || bus.ch1_DA_err;
   assign cycle_good = (crc_q == CRC_PASS) && !(sticky_err || flag_any);

   // START is never stored: it is the effective state of every cycle-start clock,
   // which lets an in-flight cycle be overrun and a new one launched in one step.
   always_comb begin
      cur_st = state;
      if (!bus.ini_done) begin
         cur_st = IDLE;
      end else if (cyc_start) begin
         cur_st = START;
      end
   end

   always_ff @(posedge sys_clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state   = cur_st;
      tx_req_c     = 1'b0;
      overrun      = cyc_start && is_busy(state);
      verdict_good = 1'b0;
      verdict_bad  = overrun;
      to_event     = overrun;
      case (cur_st)
         IDLE: begin
            next_state = IDLE;
         end
         START: begin
            if (bus.da_valid) begin
               tx_req_c   = 1'b1;
               next_state = WAIT_TX;
            end else begin
               next_state = HOLD;
            end
         end
         WAIT_TX: begin
            if (bus.tx_start) begin
               next_state = WAIT_RX;
            end else if (tmr == TX_LIM) begin
               verdict_bad = 1'b1;
               to_event    = 1'b1;
               next_state  = HOLD;
            end
         end
         WAIT_RX: begin
            if (bus.rx_done) begin
               next_state = CHECK;
            end else if (tmr == RX_LIM) begin
               verdict_bad = 1'b1;
               to_event    = 1'b1;
               next_state  = HOLD;
            end
         end
         CHECK: begin
            if (chk_last) begin
               verdict_good = cycle_good;
               verdict_bad  = !cycle_good;
               next_state   = HOLD;
            end
         end
         HOLD: begin
            next_state = HOLD;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // tmr holds the number of clocks since tx_req (WAIT_TX) or since tx_start (WAIT_RX).
   always_ff @(posedge sys_clk or posedge reset) begin
      if (reset) begin
         tmr        <= '0;
         crc_q      <= '0;
         chk_last   <= 1'b0;
         sticky_err <= 1'b0;
      end else begin
         case (cur_st)
            START: begin
               tmr        <= TMR_W'(1);
               sticky_err <= flag_any;
            end
            WAIT_TX: begin
               tmr        <= bus.tx_start ? TMR_W'(1) : tmr + TMR_W'(1);
               sticky_err <= sticky_err || flag_any;
            end
            WAIT_RX: begin
               tmr        <= tmr + TMR_W'(1);
               sticky_err <= sticky_err || flag_any;
               if (bus.rx_done) begin
                  crc_q    <= bus.rx_crc_rslt;
                  chk_last <= 1'b0;
               end
            end
            CHECK: begin
               chk_last   <= 1'b1;
               sticky_err <= sticky_err || flag_any;
            end
            default: begin
            end
         endcase
      end
   end

   // Fault thresholds look at the run count before this verdict so the flag
   // moves on the same edge as link_ok and the run counters.
   always_ff @(posedge sys_clk or posedge reset) begin
      if (reset) begin
         link_ok_q    <= 1'b0;
         link_fault_q <= 1'b0;
      end else begin
         if (!bus.ini_done) begin
            link_ok_q <= 1'b0;
         end else if (verdict_good) begin
            link_ok_q <= 1'b1;
         end else if (verdict_bad) begin
            link_ok_q <= 1'b0;
         end
         if (verdict_bad && (bad_run >= RUN_SET)) begin
            link_fault_q <= 1'b1;
         end else if (verdict_good && (good_run >= RUN_SET)) begin
            link_fault_q <= 1'b0;
         end
      end
   end

   clink_sat_cnt #(.W(RUN_W), .MAX(RUN_MAX)) u_good_run (
      .clk (sys_clk),
      .rst (reset),
      .inc (verdict_good),
      .clr (verdict_bad),
      .q   (good_run)
   );

   clink_sat_cnt #(.W(RUN_W), .MAX(RUN_MAX)) u_bad_run (
      .clk (sys_clk),
      .rst (reset),
      .inc (verdict_bad),
      .clr (verdict_good),
      .q   (bad_run)
   );

   clink_sat_cnt #(.W(CNT_W)) u_bad_cnt (
      .clk (sys_clk),
      .rst (reset),
      .inc (verdict_bad),
      .clr (1'b0),
      .q   (bad_q)
   );

   clink_sat_cnt #(.W(CNT_W)) u_to_cnt (
      .clk (sys_clk),
      .rst (reset),
      .inc (to_event),
      .clr (1'b0),
      .q   (to_q)
   );

   assign bus.tx_req     = tx_req_c;
   assign bus.cycle_sync = cyc_start;
   assign bus.link_ok    = link_ok_q;
   assign bus.link_fault = link_fault_q;
   assign bus.bad_cnt    = bad_q;
   assign bus.to_cnt     = to_q;

endmodule
